// File: rtl/param_seq_detector.sv
// Parametrised Moore serial-pattern detector with a runtime-loadable pattern,
// optional overlapping matches, an input-enable qualifier and a saturating
// match counter. The state is the number of pattern bits currently matched.
module param_seq_detector #(
    parameter int unsigned          SEQ_LEN = 5,
    parameter logic [SEQ_LEN-1:0]   PATTERN = 5'b11011,
    parameter bit                   OVERLAP = 1'b1,
    parameter int unsigned          CNT_W   = 8,
    localparam int unsigned         STATE_W = $clog2(SEQ_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               EN,
    input  logic               Din,
    input  logic               PAT_LOAD,
    input  logic [SEQ_LEN-1:0] PAT_IN,
    input  logic               CNT_CLR,
    output logic               Z,
    output logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] Next_state,
    output logic [CNT_W-1:0]   match_count
);

    localparam int                 Len     = int'(SEQ_LEN);
    localparam int                 IdxW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [STATE_W-1:0] StMatch = STATE_W'(SEQ_LEN);

    logic [STATE_W-1:0] state_q, state_d;
    logic [SEQ_LEN-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // pre[i] is the i-th pattern bit in arrival order (pattern MSB arrives first)
    logic [SEQ_LEN-1:0] pre;
    int                 cur;
    int                 best;
    logic               ok;
    logic               match_evt;

    // State, pattern and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= '0;
            pattern_q <= PATTERN;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
        end
    end

    // Next state: KMP transition evaluated against the live pattern register.
    // Because state k means the last k accepted bits equal pre[0..k-1], a
    // candidate length k is valid when pre[cur-k+1..cur-1] == pre[0..k-2] and
    // Din == pre[k-1]; the longest valid k wins.
    always_comb begin
        pre  = {<<{pattern_q}};
        // Without overlap the matched bits are dropped, so restart from empty
        cur  = (!OVERLAP && state_q == StMatch) ? 0 : int'(state_q);
        best = 0;
        ok   = 1'b0;
        for (int k = 1; k <= Len; k++) begin
            ok = (k <= cur + 1) && (Din == pre[IdxW'(k - 1)]);
            for (int j = 0; j < Len - 1; j++) begin
                if (ok && (j < k - 1) && (pre[IdxW'(cur - k + 1 + j)] != pre[IdxW'(j)])) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        // Next_state reports the stream transition; a pattern load overrides it below
        Next_state = EN ? STATE_W'(best) : state_q;

        pattern_d = pattern_q;
        state_d   = Next_state;
        if (PAT_LOAD) begin
            pattern_d = PAT_IN;
            state_d   = '0;
        end
    end

    // Match counter: counts entries into the match state, saturating; clear wins
    // over the old value but a coincident match still counts once
    always_comb begin
        match_evt = EN && !PAT_LOAD && (Next_state == StMatch);
        count_d   = count_q;
        if (CNT_CLR) begin
            count_d = match_evt ? CNT_W'(1) : '0;
        end else if (match_evt && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Moore outputs, purely from registered state
    always_comb begin
        Z           = (state_q == StMatch);
        state       = state_q;
        match_count = count_q;
    end

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench for param_seq_detector: a table of stimulus/expected
// records fed through a scoreboard queue, plus hand-written Next_state checks.
module tb_param_seq_detector;

    typedef struct {
        int         tid;
        int         which;   // 0: default, 1: no overlap, 2: 2-bit counter
        logic       rst;
        logic       en;
        logic       din;
        logic       load;
        logic [4:0] pat;
        logic       clr;
        logic [2:0] st;
        logic       z;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, din, load, clr;
    logic [4:0] pat;

    logic [2:0] st_a, st_b, st_c, ns_a, ns_b, ns_c;
    logic       z_a, z_b, z_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   cur_tid = 0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    param_seq_detector u_dut_a (
        .CLK(clk), .RESET(rst), .EN(en), .Din(din), .PAT_LOAD(load), .PAT_IN(pat),
        .CNT_CLR(clr), .Z(z_a), .state(st_a), .Next_state(ns_a), .match_count(cnt_a)
    );

    param_seq_detector #(.OVERLAP(1'b0)) u_dut_b (
        .CLK(clk), .RESET(rst), .EN(en), .Din(din), .PAT_LOAD(load), .PAT_IN(pat),
        .CNT_CLR(clr), .Z(z_b), .state(st_b), .Next_state(ns_b), .match_count(cnt_b)
    );

    param_seq_detector #(.CNT_W(2)) u_dut_c (
        .CLK(clk), .RESET(rst), .EN(en), .Din(din), .PAT_LOAD(load), .PAT_IN(pat),
        .CNT_CLR(clr), .Z(z_c), .state(st_c), .Next_state(ns_c), .match_count(cnt_c)
    );

    function automatic void add(int w, logic r, logic e, logic d, logic l, logic [4:0] p,
                                logic c, logic [2:0] s, logic [7:0] n);
        vec_t v;
        v.tid = cur_tid; v.which = w; v.rst = r; v.en = e; v.din = d; v.load = l;
        v.pat = p; v.clr = c; v.st = s; v.z = (s == 3'd5); v.cnt = n;
        tbl.push_back(v);
    endfunction

    function automatic void rs(int w);
        add(w, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 8'd0);
    endfunction

    function automatic void bt(int w, logic d, logic [2:0] s, logic [7:0] n);
        add(w, 1'b0, 1'b1, d, 1'b0, 5'd0, 1'b0, s, n);
    endfunction

    task automatic check(input string name, input int idx, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s[%0d] got %0d want %0d", name, idx, got, want);
        end
    endtask

    task automatic check_out(input vec_t v, input int idx);
        int as, az, ac;
        case (v.which)
            0:       begin as = int'(st_a); az = int'(z_a); ac = int'(cnt_a); end
            1:       begin as = int'(st_b); az = int'(z_b); ac = int'(cnt_b); end
            default: begin as = int'(st_c); az = int'(z_c); ac = int'(cnt_c); end
        endcase
        check($sformatf("t%0d_state", v.tid), idx, as, int'(v.st));
        check($sformatf("t%0d_z", v.tid), idx, az, int'(v.z));
        check($sformatf("t%0d_count", v.tid), idx, ac, int'(v.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; din = 1'b0; load = 1'b0; clr = 1'b0; pat = 5'd0;

        // 1: overlapping 11011 stream, matches after bits 5,8,11,14
        cur_tid = 1; rs(0);
        bt(0,1,1,0); bt(0,1,2,0); bt(0,0,3,0); bt(0,1,4,0); bt(0,1,5,1);
        bt(0,0,3,1); bt(0,1,4,1); bt(0,1,5,2); bt(0,0,3,2); bt(0,1,4,2);
        bt(0,1,5,3); bt(0,0,3,3); bt(0,1,4,3); bt(0,1,5,4);
        // 2: same stream without overlap, matches after bits 5,11
        cur_tid = 2; rs(1);
        bt(1,1,1,0); bt(1,1,2,0); bt(1,0,3,0); bt(1,1,4,0); bt(1,1,5,1);
        bt(1,0,0,1); bt(1,1,1,1); bt(1,1,2,1); bt(1,0,3,1); bt(1,1,4,1);
        bt(1,1,5,2); bt(1,0,0,2); bt(1,1,1,2); bt(1,1,2,2);
        // 3: failure-function path 1,1,1,0,1,1
        cur_tid = 3; rs(0);
        bt(0,1,1,0); bt(0,1,2,0); bt(0,1,2,0); bt(0,0,3,0); bt(0,1,4,0); bt(0,1,5,1);
        // 4: EN low for three cycles mid-pattern
        cur_tid = 4; rs(0);
        bt(0,1,1,0); bt(0,1,2,0); bt(0,0,3,0);
        add(0,0,0,1,0,5'd0,0,3,0); add(0,0,0,0,0,5'd0,0,3,0); add(0,0,0,1,0,5'd0,0,3,0);
        bt(0,1,4,0); bt(0,1,5,1);
        // 7: load one bit before a match: progress lost, no count
        cur_tid = 7; rs(0);
        bt(0,1,1,0); bt(0,1,2,0); bt(0,0,3,0); bt(0,1,4,0);
        add(0,0,1,1,1,5'b11011,0,0,0); bt(0,1,1,0);
        // 5: load 10101 mid-sequence, matches after bits 5,7
        cur_tid = 5; rs(0);
        bt(0,1,1,0); bt(0,1,2,0); bt(0,0,3,0);
        add(0,0,1,1,1,5'b10101,0,0,0);
        bt(0,1,1,0); bt(0,0,2,0); bt(0,1,3,0); bt(0,0,4,0); bt(0,1,5,1);
        bt(0,0,4,1); bt(0,1,5,2);
        // 8: all-ones pattern, match state re-entered from itself
        cur_tid = 8; add(0,0,1,0,1,5'b11111,0,0,2);
        bt(0,1,1,2); bt(0,1,2,2); bt(0,1,3,2); bt(0,1,4,2); bt(0,1,5,3);
        bt(0,1,5,4); bt(0,1,5,5);
        // 9: reset restores the parameter pattern
        cur_tid = 9; rs(0);
        bt(0,1,1,0); bt(0,1,2,0); bt(0,0,3,0); bt(0,1,4,0); bt(0,1,5,1);
        // 6: 2-bit counter saturation, clear on match, clear alone, reset mid-pattern
        cur_tid = 6; rs(2);
        bt(2,1,1,0); bt(2,1,2,0); bt(2,0,3,0); bt(2,1,4,0); bt(2,1,5,1);
        bt(2,0,3,1); bt(2,1,4,1); bt(2,1,5,2);
        bt(2,0,3,2); bt(2,1,4,2); bt(2,1,5,3);
        bt(2,0,3,3); bt(2,1,4,3); bt(2,1,5,3);
        bt(2,0,3,3); bt(2,1,4,3); bt(2,1,5,3);
        bt(2,0,3,3); bt(2,1,4,3);
        add(2,0,1,1,0,5'd0,1,5,1);
        add(2,0,0,0,0,5'd0,1,5,0);
        bt(2,0,3,0); bt(2,1,4,0);
        add(2,1,1,1,0,5'd0,0,0,0);
        bt(2,1,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; en = tbl[i].en; din = tbl[i].din;
            load = tbl[i].load; pat = tbl[i].pat; clr = tbl[i].clr;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty[%0d] got 0 want 1", i);
            end else begin
                check_out(exp_q.pop_front(), i);
            end
        end

        // Hand sequence: combinational Next_state while held and when advancing
        @(negedge clk); rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
        @(negedge clk); rst = 1'b0; en = 1'b1; din = 1'b1;
        @(negedge clk); din = 1'b1;
        @(negedge clk); din = 1'b0;
        @(negedge clk); en = 1'b0; din = 1'b1;
        #1;
        check("hold_next_state", 0, int'(ns_a), 3);
        @(negedge clk); din = 1'b0;
        #1;
        check("hold_state", 0, int'(st_a), 3);
        check("hold_next_state", 1, int'(ns_a), 3);
        @(negedge clk); en = 1'b1; din = 1'b1;
        #1;
        check("adv_next_state", 0, int'(ns_a), 4);
        @(negedge clk); din = 1'b1;
        #1;
        check("adv_next_state", 1, int'(ns_a), 5);
        @(posedge clk); #1;
        check("final_z", 0, int'(z_a), 1);
        @(negedge clk); en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
